// File: rtl/div_pkg.sv
// Shared constants and operand helpers for the iterative RV32M divider.
package div_pkg;

  localparam int REG_SIZE = 31;
  localparam int XLEN     = REG_SIZE + 1;

  localparam logic [4:0] ALU_DIV  = 5'b01100;
  localparam logic [4:0] ALU_DIVU = 5'b01101;
  localparam logic [4:0] ALU_REM  = 5'b01110;
  localparam logic [4:0] ALU_REMU = 5'b01111;

  function automatic logic op_valid(input logic [4:0] op);
    case (op)
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: op_valid = 1'b1;
      default:                              op_valid = 1'b0;
    endcase
  endfunction

  function automatic logic op_signed(input logic [4:0] op);
    case (op)
      ALU_DIV, ALU_REM: op_signed = 1'b1;
      default:          op_signed = 1'b0;
    endcase
  endfunction

  function automatic logic op_rem(input logic [4:0] op);
    case (op)
      ALU_REM, ALU_REMU: op_rem = 1'b1;
      default:           op_rem = 1'b0;
    endcase
  endfunction

  // Two's-complement negate when requested; 0x80000000 maps to itself, which is its magnitude.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    if (neg) begin
      cond_neg = ~v + 32'd1;
    end else begin
      cond_neg = v;
    end
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift, trial-subtract, restore or keep.
module div_step
  import div_pkg::*;
(
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] dvsr,
  output logic [XLEN:0]   rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN+1:0] shifted_s;
  logic [XLEN+1:0] diff_s;

  // The dividend bits leave quo from the top while quotient bits enter at the bottom.
  always_comb begin
    shifted_s = {rem, quo[XLEN-1]};
    diff_s    = shifted_s - {2'b00, dvsr};
    if (!diff_s[XLEN+1]) begin
      rem_next = diff_s[XLEN:0];
      quo_next = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_next = shifted_s[XLEN:0];
      quo_next = {quo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div.sv
// Iterative 32-bit RV32M divider (DIV/DIVU/REM/REMU): 32 restoring steps plus a
// one-cycle short path for divide-by-zero, signed overflow and unsupported ops.
module div
  import div_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [4:0]      ALUCtrl,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    SPEC = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [4:0]      cnt_r, cnt_s;
  logic [XLEN:0]   rem_r, rem_s;
  logic [XLEN-1:0] quo_r, quo_s;
  logic [XLEN-1:0] dvsr_r, dvsr_s;
  logic [4:0]      op_r, op_s;
  logic            neg_a_r, neg_a_s;
  logic            neg_b_r, neg_b_s;
  logic [XLEN-1:0] result_r, result_s;
  logic            done_r, done_s;
  logic            busy_r, busy_s;

  logic [XLEN:0]   step_rem_s;
  logic [XLEN-1:0] step_quo_s;
  logic            neg_q_s, neg_r_s;

  div_step u_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .dvsr     (dvsr_r),
    .rem_next (step_rem_s),
    .quo_next (step_quo_s)
  );

  // State and datapath registers; every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= 5'd0;
      rem_r    <= '0;
      quo_r    <= '0;
      dvsr_r   <= '0;
      op_r     <= 5'd0;
      neg_a_r  <= 1'b0;
      neg_b_r  <= 1'b0;
      result_r <= '0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      rem_r    <= rem_s;
      quo_r    <= quo_s;
      dvsr_r   <= dvsr_s;
      op_r     <= op_s;
      neg_a_r  <= neg_a_s;
      neg_b_r  <= neg_b_s;
      result_r <= result_s;
      done_r   <= done_s;
      busy_r   <= busy_s;
    end
  end

  // Next-state and datapath update. The done cycle blocks a new accept so that
  // the earliest back-to-back start is the cycle after done.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    rem_s    = rem_r;
    quo_s    = quo_r;
    dvsr_s   = dvsr_r;
    op_s     = op_r;
    neg_a_s  = neg_a_r;
    neg_b_s  = neg_b_r;
    result_s = result_r;
    done_s   = 1'b0;
    neg_q_s  = op_signed(op_r) & (neg_a_r ^ neg_b_r);
    neg_r_s  = op_signed(op_r) & neg_a_r;
    if (done_r) begin
      busy_s = 1'b0;
    end else begin
      busy_s = busy_r;
    end

    if (flush) begin
      state_s = IDLE;
      busy_s  = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start && !done_r) begin
            op_s    = ALUCtrl;
            neg_a_s = A[XLEN-1];
            neg_b_s = B[XLEN-1];
            busy_s  = 1'b1;
            if (!op_valid(ALUCtrl)) begin
              state_s  = SPEC;
              result_s = '0;
              done_s   = 1'b1;
            end else if (B == 32'd0) begin
              state_s  = SPEC;
              result_s = op_rem(ALUCtrl) ? A : 32'hFFFF_FFFF;
              done_s   = 1'b1;
            end else if (op_signed(ALUCtrl) && (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF)) begin
              state_s  = SPEC;
              result_s = op_rem(ALUCtrl) ? 32'h0000_0000 : 32'h8000_0000;
              done_s   = 1'b1;
            end else begin
              state_s = CALC;
              quo_s   = cond_neg(A, op_signed(ALUCtrl) & A[XLEN-1]);
              dvsr_s  = cond_neg(B, op_signed(ALUCtrl) & B[XLEN-1]);
              rem_s   = '0;
              cnt_s   = 5'd0;
            end
          end else begin
            state_s = IDLE;
          end
        end
        CALC: begin
          rem_s = step_rem_s;
          quo_s = step_quo_s;
          cnt_s = cnt_r + 5'd1;
          if (cnt_r == 5'd31) begin
            state_s = FIX;
          end else begin
            state_s = CALC;
          end
        end
        FIX: begin
          if (op_rem(op_r)) begin
            result_s = cond_neg(rem_r[XLEN-1:0], neg_r_s);
          end else begin
            result_s = cond_neg(quo_r, neg_q_s);
          end
          done_s  = 1'b1;
          state_s = IDLE;
        end
        SPEC: begin
          state_s = IDLE;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for the iterative divider.
module tb_div;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic [4:0]  ALUCtrl = 5'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;
  int done_cnt;

  div dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .flush   (flush),
    .A       (A),
    .B       (B),
    .ALUCtrl (ALUCtrl),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait from cycle `from` until done, bounded; leaves the bench inside the done cycle.
  task automatic wait_done(input int from, output int at);
    at = from;
    while (done !== 1'b1 && at < 80) begin
      tick();
      at++;
    end
  endtask

  // Issue one operation, check latency, busy/result at done, and idle state afterwards.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int at;
    ALUCtrl = op;
    A = a;
    B = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    A = 32'hDEAD_BEEF;
    B = 32'hCAFE_F00D;
    wait_done(1, at);
    chk({tag, "_lat"}, at, lat);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd1);
    chk({tag, "_result"}, result, exp);
    tick();
    chk({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int at;
    #2;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    run_op("divu_100_7", ALU_DIVU, 32'd100, 32'd7, 32'd14, 34);
    run_op("remu_100_7", ALU_REMU, 32'd100, 32'd7, 32'd2, 34);
    run_op("div_m7_2", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run_op("rem_m7_2", ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_op("div_100_m7", ALU_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 34);
    run_op("rem_100_m7", ALU_REM, 32'd100, 32'hFFFF_FFF9, 32'd2, 34);
    run_op("div_by0", ALU_DIV, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu_by0", ALU_REMU, 32'h1234_5678, 32'd0, 32'h1234_5678, 1);
    run_op("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("divu_big", ALU_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);
    run_op("bad_op", 5'd0, 32'd50, 32'd5, 32'd0, 1);
    run_op("divu_max_1", ALU_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);
    run_op("remu_b2b", ALU_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, 34);

    // start pulsed at cycle 10 of a busy DIVU 1000/10 must be ignored
    ALUCtrl = ALU_DIVU; A = 32'd1000; B = 32'd10; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    ALUCtrl = ALU_DIVU; A = 32'd5; B = 32'd1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(11, at);
    chk("ign_start_lat", at, 34);
    chk("ign_start_result", result, 32'd100);
    tick();
    chk("ign_start_idle", {31'd0, busy}, 32'd0);

    // flush at cycle 20: no done, result held, busy drops next cycle
    ALUCtrl = ALU_DIVU; A = 32'd1000; B = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    done_cnt = 0;
    for (int i = 1; i < 20; i++) begin
      if (done === 1'b1) done_cnt++;
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_result", result, 32'd100);
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1) done_cnt++;
      tick();
    end
    chk("flush_no_done", done_cnt, 0);
    chk("flush_result_late", result, 32'd100);

    // flush and start together in IDLE: nothing accepted
    ALUCtrl = ALU_DIV; A = 32'd9; B = 32'd0; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", {31'd0, busy}, 32'd0);
    chk("flush_start_done", {31'd0, done}, 32'd0);
    chk("flush_start_result", result, 32'd100);

    // reset low at cycle 15 clears outputs immediately
    ALUCtrl = ALU_DIVU; A = 32'd77; B = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    chk("rst_mid_result", result, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_after_busy", {31'd0, busy}, 32'd0);
    run_op("post_rst_divu", ALU_DIVU, 32'd77, 32'd7, 32'd11, 34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
